// File: rtl/tdm_demux_1x4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1x4
// Splits a serial four-channel TDM sample stream into a parallel frame
// register. A sample marked with din_sync is channel 0. Channels 1..3 follow
// on later valid cycles. When channel 3 arrives, all four channels are
// published together and frame_valid pulses for one cycle.
//
// Optional feature: define TDM_DEMUX_ERR_EN to add the sync error outputs.
//
// Parameters
//   W            sample width in bits (1..32)
// Ports
//   clk          single clock; all logic runs on the rising edge
//   rst          synchronous, active-high reset
//   din          serial TDM sample
//   din_valid    din carries a sample this cycle
//   din_sync     din is channel 0 (frame start); ignored when din_valid=0
//   ch_out       frame register; channel k is at bits [k*W +: W]
//   frame_valid  one-cycle pulse in the cycle ch_out takes a new frame
//   ch_idx       channel index expected for the next accepted sample
//   locked       high while the FSM is in COLLECT
//   sync_err     (TDM_DEMUX_ERR_EN) one-cycle pulse for each sync error
//   err_cnt      (TDM_DEMUX_ERR_EN) sync error count, saturates at 255
// -----------------------------------------------------------------------------
module tdm_demux_1x4 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           din_sync,
    output logic [4*W-1:0] ch_out,
    output logic           frame_valid,
    output logic [1:0]     ch_idx,
    output logic           locked
`ifdef TDM_DEMUX_ERR_EN
    ,
    output logic           sync_err,
    output logic [7:0]     err_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [1:0]     ch_idx_r;
    logic [1:0]     ch_idx_nxt_s;
    // Channel 3 is never shadowed. It goes straight from din into ch_out.
    logic [W-1:0]   shadow_r [0:2];
    logic [4*W-1:0] ch_out_r;
    logic           frame_valid_r;
    logic           store_s;
    logic [1:0]     store_sel_s;
    logic           frame_done_s;

    // Compute the next state and channel index, and which shadow slot to write.
    always_comb begin
        state_nxt_s  = state_r;
        ch_idx_nxt_s = ch_idx_r;
        store_s      = 1'b0;
        store_sel_s  = 2'd0;
        frame_done_s = 1'b0;
        if (din_valid) begin
            case (state_r)
                ST_HUNT: begin
                    if (din_sync) begin
                        store_s      = 1'b1;
                        store_sel_s  = 2'd0;
                        ch_idx_nxt_s = 2'd1;
                        state_nxt_s  = ST_COLLECT;
                    end else begin
                        // Still hunting for a frame start; drop the sample.
                        state_nxt_s  = ST_HUNT;
                    end
                end
                ST_COLLECT: begin
                    if (ch_idx_r == 2'd0) begin
                        if (din_sync) begin
                            store_s      = 1'b1;
                            store_sel_s  = 2'd0;
                            ch_idx_nxt_s = 2'd1;
                        end else begin
                            // A frame start was expected but did not come: lose lock.
                            state_nxt_s  = ST_HUNT;
                            ch_idx_nxt_s = 2'd0;
                        end
                    end else begin
                        if (din_sync) begin
                            // Sync arrived early. Restart the frame at this sample
                            // without dropping lock.
                            store_s      = 1'b1;
                            store_sel_s  = 2'd0;
                            ch_idx_nxt_s = 2'd1;
                        end else if (ch_idx_r == 2'd3) begin
                            frame_done_s = 1'b1;
                            ch_idx_nxt_s = 2'd0;
                        end else begin
                            store_s      = 1'b1;
                            store_sel_s  = ch_idx_r;
                            ch_idx_nxt_s = ch_idx_r + 2'd1;
                        end
                    end
                end
                default: begin
                    state_nxt_s  = ST_HUNT;
                    ch_idx_nxt_s = 2'd0;
                end
            endcase
        end else begin
            // Idle cycle: hold everything and run no timeout.
            state_nxt_s  = state_r;
            ch_idx_nxt_s = ch_idx_r;
        end
    end

    // State, index, shadow and frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_HUNT;
            ch_idx_r      <= 2'd0;
            shadow_r[0]   <= {W{1'b0}};
            shadow_r[1]   <= {W{1'b0}};
            shadow_r[2]   <= {W{1'b0}};
            ch_out_r      <= {(4*W){1'b0}};
            frame_valid_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            ch_idx_r      <= ch_idx_nxt_s;
            frame_valid_r <= frame_done_s;
            if (store_s) begin
                case (store_sel_s)
                    2'd0:    shadow_r[0] <= din;
                    2'd1:    shadow_r[1] <= din;
                    2'd2:    shadow_r[2] <= din;
                    default: shadow_r[0] <= shadow_r[0];
                endcase
            end
            if (frame_done_s) begin
                ch_out_r <= {din, shadow_r[2], shadow_r[1], shadow_r[0]};
            end
        end
    end

    assign ch_out      = ch_out_r;
    assign frame_valid = frame_valid_r;
    assign ch_idx      = ch_idx_r;
    assign locked      = (state_r == ST_COLLECT);

`ifdef TDM_DEMUX_ERR_EN
    logic       err_s;
    logic       sync_err_r;
    logic [7:0] err_cnt_r;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // A sync error is either a missing sync at channel 0 or an early sync at channels 1..3.
    always_comb begin
        err_s = 1'b0;
        if (din_valid && (state_r == ST_COLLECT)) begin
            err_s = (ch_idx_r == 2'd0) ? !din_sync : din_sync;
        end else begin
            err_s = 1'b0;
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err_r <= 1'b0;
            err_cnt_r  <= 8'd0;
        end else begin
            sync_err_r <= err_s;
            if (err_s) begin
                err_cnt_r <= sat_inc8(err_cnt_r);
            end
        end
    end

    assign sync_err = sync_err_r;
    assign err_cnt  = err_cnt_r;
`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
module tb_tdm_demux_1x4;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_sync;
    logic [31:0] ch_out;
    logic        frame_valid;
    logic [1:0]  ch_idx;
    logic        locked;
`ifdef TDM_DEMUX_ERR_EN
    logic        sync_err;
    logic [7:0]  err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int fv_total = 0;

    tdm_demux_1x4 #(.W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_sync    (din_sync),
        .ch_out      (ch_out),
        .frame_valid (frame_valid),
        .ch_idx      (ch_idx),
        .locked      (locked)
`ifdef TDM_DEMUX_ERR_EN
        ,
        .sync_err    (sync_err),
        .err_cnt     (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid === 1'b1) fv_total++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic [7:0] d);
        din_valid = 1'b1;
        din_sync  = s;
        din       = d;
        step();
        din_valid = 1'b0;
        din_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b0;
            din_sync  = 1'b1;
            din       = 8'hEE;
            step();
        end
        din_sync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; din_valid = 1'b0; din_sync = 1'b0; din = 8'h00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ch_out !== 32'h0) begin n_fail++; $display("FAIL reset_ch_out got %h exp %h", ch_out, 32'h0); end
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b exp 0", frame_valid); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
        n_checks++; if (ch_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", ch_idx); end
`ifdef TDM_DEMUX_ERR_EN
        n_checks++; if (err_cnt !== 8'd0 || sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got cnt %0d pulse %b exp 0 0", err_cnt, sync_err); end
`endif
    endtask

    task automatic test_basic_frame();
        do_reset();
        send(1'b1, 8'h11);
        n_checks++; if (locked !== 1'b1 || ch_idx !== 2'd1) begin n_fail++; $display("FAIL basic_lock got locked %b idx %0d exp 1 1", locked, ch_idx); end
        send(1'b0, 8'h22);
        n_checks++; if (ch_idx !== 2'd2 || frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idx2 got idx %0d fv %b exp 2 0", ch_idx, frame_valid); end
        send(1'b0, 8'h33);
        n_checks++; if (ch_idx !== 2'd3 || ch_out !== 32'h0) begin n_fail++; $display("FAIL basic_idx3 got idx %0d out %h exp 3 0", ch_idx, ch_out); end
        send(1'b0, 8'h44);
        n_checks++; if (ch_out !== 32'h44332211) begin n_fail++; $display("FAIL basic_ch_out got %h exp %h", ch_out, 32'h44332211); end
        n_checks++; if (frame_valid !== 1'b1 || ch_idx !== 2'd0) begin n_fail++; $display("FAIL basic_fv got fv %b idx %0d exp 1 0", frame_valid, ch_idx); end
        idle(1);
        n_checks++; if (frame_valid !== 1'b0 || ch_out !== 32'h44332211 || locked !== 1'b1) begin n_fail++; $display("FAIL basic_after got fv %b out %h locked %b exp 0 44332211 1", frame_valid, ch_out, locked); end
    endtask

    task automatic test_hunt_discard();
        do_reset();
        send(1'b0, 8'hAA);
        send(1'b0, 8'hBB);
        n_checks++; if (locked !== 1'b0 || ch_out !== 32'h0 || ch_idx !== 2'd0) begin n_fail++; $display("FAIL hunt_ignore got locked %b out %h idx %0d exp 0 0 0", locked, ch_out, ch_idx); end
        send(1'b1, 8'h01);
        send(1'b0, 8'h02);
        send(1'b0, 8'h03);
        send(1'b0, 8'h04);
        n_checks++; if (ch_out !== 32'h04030201 || frame_valid !== 1'b1) begin n_fail++; $display("FAIL hunt_frame got out %h fv %b exp 04030201 1", ch_out, frame_valid); end
    endtask

    task automatic test_resync();
        do_reset();
        send(1'b1, 8'h10);
        send(1'b0, 8'h20);
        send(1'b1, 8'h55);
        n_checks++; if (locked !== 1'b1 || ch_idx !== 2'd1 || ch_out !== 32'h0) begin n_fail++; $display("FAIL resync_state got locked %b idx %0d out %h exp 1 1 0", locked, ch_idx, ch_out); end
`ifdef TDM_DEMUX_ERR_EN
        n_checks++; if (sync_err !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL resync_err got pulse %b cnt %0d exp 1 1", sync_err, err_cnt); end
`endif
        send(1'b0, 8'h66);
`ifdef TDM_DEMUX_ERR_EN
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL resync_pulse_len got %b exp 0", sync_err); end
`endif
        send(1'b0, 8'h77);
        send(1'b0, 8'h88);
        n_checks++; if (ch_out !== 32'h88776655 || frame_valid !== 1'b1) begin n_fail++; $display("FAIL resync_frame got out %h fv %b exp 88776655 1", ch_out, frame_valid); end
    endtask

    task automatic test_lost_sync();
        do_reset();
        send(1'b1, 8'h11); send(1'b0, 8'h22); send(1'b0, 8'h33); send(1'b0, 8'h44);
        send(1'b0, 8'h99);
        n_checks++; if (locked !== 1'b0 || ch_idx !== 2'd0 || ch_out !== 32'h44332211) begin n_fail++; $display("FAIL lost_sync got locked %b idx %0d out %h exp 0 0 44332211", locked, ch_idx, ch_out); end
`ifdef TDM_DEMUX_ERR_EN
        n_checks++; if (sync_err !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL lost_sync_err got pulse %b cnt %0d exp 1 1", sync_err, err_cnt); end
`endif
        send(1'b0, 8'h5A);
        n_checks++; if (locked !== 1'b0 || ch_out !== 32'h44332211) begin n_fail++; $display("FAIL lost_sync_hunt got locked %b out %h exp 0 44332211", locked, ch_out); end
    endtask

    task automatic test_gaps();
        int fv_start;
        do_reset();
        fv_start = fv_total;
        send(1'b1, 8'hA1);
        send(1'b0, 8'hB2);
        idle(1);
        send(1'b0, 8'hC3);
        idle(2);
        n_checks++; if (ch_idx !== 2'd3 || locked !== 1'b1) begin n_fail++; $display("FAIL gaps_hold got idx %0d locked %b exp 3 1", ch_idx, locked); end
        send(1'b0, 8'hD4);
        idle(3);
        n_checks++; if (ch_out !== 32'hD4C3B2A1) begin n_fail++; $display("FAIL gaps_ch_out got %h exp %h", ch_out, 32'hD4C3B2A1); end
        n_checks++; if (fv_total - fv_start !== 1) begin n_fail++; $display("FAIL gaps_fv_count got %0d exp 1", fv_total - fv_start); end
    endtask

    task automatic test_back_to_back();
        int fv_start;
        do_reset();
        fv_start = fv_total;
        send(1'b1, 8'h01); send(1'b0, 8'h02); send(1'b0, 8'h03); send(1'b0, 8'h04);
        n_checks++; if (ch_out !== 32'h04030201) begin n_fail++; $display("FAIL b2b_first got %h exp 04030201", ch_out); end
        send(1'b1, 8'h05);
        n_checks++; if (frame_valid !== 1'b0 || ch_idx !== 2'd1 || locked !== 1'b1) begin n_fail++; $display("FAIL b2b_next_sync got fv %b idx %0d locked %b exp 0 1 1", frame_valid, ch_idx, locked); end
        send(1'b0, 8'h06); send(1'b0, 8'h07); send(1'b0, 8'h08);
        n_checks++; if (ch_out !== 32'h08070605 || frame_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second got out %h fv %b exp 08070605 1", ch_out, frame_valid); end
        idle(1);
        n_checks++; if (fv_total - fv_start !== 2) begin n_fail++; $display("FAIL b2b_fv_count got %0d exp 2", fv_total - fv_start); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send(1'b1, 8'hC1); send(1'b0, 8'hC2); send(1'b0, 8'hC3); send(1'b0, 8'hC4);
        send(1'b1, 8'h12);
        send(1'b0, 8'h34);
        rst = 1'b1; din_valid = 1'b1; din_sync = 1'b1; din = 8'h56;
        step();
        rst = 1'b0; din_valid = 1'b0; din_sync = 1'b0;
        n_checks++; if (ch_out !== 32'h0 || ch_idx !== 2'd0 || locked !== 1'b0 || frame_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state got out %h idx %0d locked %b fv %b exp 0 0 0 0", ch_out, ch_idx, locked, frame_valid); end
        send(1'b0, 8'h78); send(1'b0, 8'h9A); send(1'b0, 8'hBC); send(1'b0, 8'hDE);
        n_checks++; if (ch_out !== 32'h0 || locked !== 1'b0 || ch_idx !== 2'd0) begin n_fail++; $display("FAIL midrst_ignore got out %h locked %b idx %0d exp 0 0 0", ch_out, locked, ch_idx); end
    endtask

`ifdef TDM_DEMUX_ERR_EN
    task automatic test_err_saturation();
        do_reset();
        send(1'b1, 8'h01);
        for (int i = 0; i < 300; i++) send(1'b1, 8'h02);
        n_checks++; if (err_cnt !== 8'd255 || sync_err !== 1'b1) begin n_fail++; $display("FAIL err_sat got cnt %0d pulse %b exp 255 1", err_cnt, sync_err); end
        n_checks++; if (ch_out !== 32'h0) begin n_fail++; $display("FAIL err_sat_out got %h exp 0", ch_out); end
    endtask
`endif

    initial begin
        rst = 1'b1; din = 8'h00; din_valid = 1'b0; din_sync = 1'b0;
        test_reset();
        test_basic_frame();
        test_hunt_discard();
        test_resync();
        test_lost_sync();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
`ifdef TDM_DEMUX_ERR_EN
        test_err_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x4.md
TDM_DEMUX_1X4 -- requirements
Module: tdm_demux_1x4

Interface
REQ-001 The block SHALL provide parameter: W, 8, sample width in bits (1..32).
REQ-002 The block SHALL provide port: clk  input  1  single clock; all logic rising-edge.
REQ-003 The block SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL provide port: din  input  W  serial TDM sample.
REQ-005 The block SHALL provide port: din_valid  input  1  din carries a sample this cycle.
REQ-006 The block SHALL provide port: din_sync  input  1  qualifies din as channel 0 (frame start); ignored when din_valid=0.
REQ-007 The block SHALL provide port: ch_out  output  4*W  frame register, channel k at bits [k*W +: W].
REQ-008 The block SHALL provide port: frame_valid  output  1  one-cycle pulse, ch_out updated with a new frame.
REQ-009 The block SHALL provide port: ch_idx  output  2  channel index expected for the next accepted sample.
REQ-010 The block SHALL provide port: locked  output  1  FSM in COLLECT.

Function
REQ-011 The block SHALL implement FSM states HUNT and COLLECT, with HUNT on reset.
REQ-012 In HUNT, the block SHALL discard samples with din_valid=1, din_sync=0.
REQ-013 In HUNT, din_valid=1 with din_sync=1 SHALL store din as shadow ch0, set ch_idx=1 and enter COLLECT.
REQ-014 In COLLECT with ch_idx=1..3 and din_sync=0, din_valid=1 SHALL store din in shadow[ch_idx] and increment ch_idx modulo 4.
REQ-015 On acceptance of channel 3, the block SHALL load ch_out with shadow0..2 and din, all together in a single clock edge, SHALL assert frame_valid in the same cycle as the ch_out update (1 cycle after the ch3 input cycle), and SHALL wrap ch_idx to 0.
REQ-016 In COLLECT with ch_idx=0, din_valid=1 with din_sync=1 SHALL store din as shadow ch0 and set ch_idx=1.
REQ-017 In COLLECT with ch_idx=0, din_valid=1 with din_sync=0 SHALL count as a sync error: discard the sample, enter HUNT, set ch_idx=0.
REQ-018 In COLLECT with ch_idx=1..3, din_valid=1 with din_sync=1 SHALL count as a sync error: abandon the partial frame, store din as shadow ch0, set ch_idx=1 and stay in COLLECT.
REQ-019 ch_out SHALL change only on frame completion and SHALL hold its value otherwise, including across sync errors and idle cycles.
REQ-020 Cycles with din_valid=0 SHALL leave all state unchanged, with no timeout.
REQ-021 Back-to-back valid samples every cycle SHALL be sustained with no lost samples.

Reset
REQ-022 When rst=1 at a clock edge, the block SHALL clear state=HUNT, ch_idx=0, ch_out=0, shadow=0, frame_valid=0 and locked=0; rst SHALL override din_valid in the same cycle.
REQ-023 Reset mid-frame SHALL discard the partial frame, and the first frame after reset SHALL require din_sync.

Configuration
REQ-024 When TDM_DEMUX_ERR_EN is defined, the block SHALL add ports sync_err (output, 1: one-cycle pulse per REQ-017/REQ-018 event, registered, 1 cycle after the offending input) and err_cnt (output, 8: saturating at 255, reset 0).
REQ-025 When TDM_DEMUX_ERR_EN is undefined, those ports and their logic SHALL be absent, and error handling SHALL otherwise be identical.

Verification (W=8)
REQ-026 Reset then the stream {sync:0x11, 0x22, 0x33, 0x44} on consecutive cycles SHALL give ch_out=0x44332211 and frame_valid high exactly one cycle, one cycle after 0x44.
REQ-027 Samples 0xAA, 0xBB without sync from reset SHALL be ignored (locked=0, ch_out=0); the following {sync:0x01, 0x02, 0x03, 0x04} SHALL give ch_out=0x04030201.
REQ-028 {sync:0x10, 0x20} followed by {sync:0x55, 0x66, 0x77, 0x88} SHALL give ch_out=0x88776655 and one sync_err pulse (ERR_EN).
REQ-029 After a full frame, a sample 0x99 without sync SHALL give locked=0, sync_err=1, err_cnt=1, and ch_out unchanged.
REQ-030 A frame with din_valid gaps of 0-3 idle cycles between samples SHALL give the same ch_out as gapless, with a single frame_valid.
REQ-031 rst asserted after ch1 of a frame SHALL give ch_out=0 and ch_idx=0; subsequent non-sync samples SHALL be ignored.
